// File: rtl/rf_wport_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wport_arb_pkg
//  Description : Shared widths, bus layouts and helpers for the register-file
//                write-port arbiter. Bus widths mirror the CPU-wide mycpu.h
//                definitions so the arbiter plugs into the existing buses.
//  Revision    : 1.0  initial release
// ============================================================================
package rf_wport_arb_pkg;

  localparam int RF_WADDR_WD      = 5;
  localparam int RF_DATA_WD       = 32;
  // {waddr, wdata} as delivered by the multi-cycle unit
  localparam int MU_TO_ARB_BUS_WD = RF_WADDR_WD + RF_DATA_WD;
  // {we, waddr, wdata}; reused for the rf_* output bundle
  localparam int WS_TO_RF_BUS_WD  = 1 + RF_WADDR_WD + RF_DATA_WD;

  // Owner of the write port in a given cycle
  typedef enum logic {
    SRC_WB = 1'b0,
    SRC_MU = 1'b1
  } rf_src_e;

  // One-hot register decode; r0 never appears as pending
  function automatic logic [31:0] reg_onehot(input logic [RF_WADDR_WD-1:0] a);
    logic [31:0] m;
    m    = '0;
    m[a] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wport_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wport_fifo
//  Description : Circular buffer for MU results awaiting the write port.
//                Each entry is {live, waddr, wdata}; entries whose destination
//                is overwritten by a younger WB write are marked dead but stay
//                queued. Exports the pending-destination mask of live entries.
//  Ports       : clk, resetn        - clock, synchronous active-low reset
//                push, push_bus     - enqueue {waddr, wdata}
//                pop                - dequeue head
//                kill_en, kill_addr - clear live on entries targeting kill_addr
//                empty, full        - occupancy flags (registered state)
//                head_*             - head entry fields
//                pend_mask          - OR of one-hot waddr over live entries
//  Revision    : 1.0  initial release
// ============================================================================
module rf_wport_fifo
  import rf_wport_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        push,
  input  logic [MU_TO_ARB_BUS_WD-1:0] push_bus,
  input  logic                        pop,
  input  logic                        kill_en,
  input  logic [RF_WADDR_WD-1:0]      kill_addr,
  output logic                        empty,
  output logic                        full,
  output logic                        head_live,
  output logic [RF_WADDR_WD-1:0]      head_waddr,
  output logic [RF_DATA_WD-1:0]       head_wdata,
  output logic [31:0]                 pend_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]       live_q, live_d;
  logic [RF_WADDR_WD-1:0] waddr_q [DEPTH];
  logic [RF_WADDR_WD-1:0] waddr_d [DEPTH];
  logic [RF_DATA_WD-1:0]  wdata_q [DEPTH];
  logic [RF_DATA_WD-1:0]  wdata_d [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;

  logic [RF_WADDR_WD-1:0] push_waddr;
  logic [RF_DATA_WD-1:0]  push_wdata;

  assign {push_waddr, push_wdata} = push_bus;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign head_live  = live_q[rd_ptr_q];
  assign head_waddr = waddr_q[rd_ptr_q];
  assign head_wdata = wdata_q[rd_ptr_q];

  always_comb begin
    live_d   = live_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // A younger WB write to the same register makes the buffered result stale
    if (kill_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr_q[i] == kill_addr) live_d[i] = 1'b0;
      end
    end

    // Popped slots are cleared so free slots never feed pend_mask
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PW'(1);
    end

    // Push never targets the popped slot: push requires !full
    if (push) begin
      live_d[wr_ptr_q]  = (push_waddr != '0) &&
                          !(kill_en && (kill_addr == push_waddr));
      waddr_d[wr_ptr_q] = push_waddr;
      wdata_d[wr_ptr_q] = push_wdata;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      live_q   <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pend_mask = pend_mask | reg_onehot(waddr_q[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_wport_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wport_arb
//  Description : Arbiter for the single register-file write port, shared by
//                the in-order WB stage and the out-of-band multi-cycle unit.
//                WB has priority; a FIFO head that waits STARVE_MAX cycles
//                forces an MU grant and stalls WB for one cycle.
//                Optional statistics counters: define RF_WPORT_STAT_EN.
//  Ports       : clk, resetn                - clock, sync active-low reset
//                ws_we/ws_waddr/ws_wdata    - WB write request
//                ws_stall                   - WB must hold its write
//                mu_valid/mu_waddr/mu_wdata - MU result
//                mu_ready                   - FIFO can accept an MU result
//                rf_we/rf_waddr/rf_wdata    - register-file write port
//                rf_src                     - 0 = WB, 1 = MU owns the port
//                pend_mask                  - live buffered MU destinations
//                stat_mu_cnt/stat_force_cnt - MU / forced grant counters
//  Revision    : 1.0  initial release
// ============================================================================
module rf_wport_arb
  import rf_wport_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   ws_we,
  input  logic [RF_WADDR_WD-1:0] ws_waddr,
  input  logic [RF_DATA_WD-1:0]  ws_wdata,
  output logic                   ws_stall,
  input  logic                   mu_valid,
  output logic                   mu_ready,
  input  logic [RF_WADDR_WD-1:0] mu_waddr,
  input  logic [RF_DATA_WD-1:0]  mu_wdata,
  output logic                   rf_we,
  output logic [RF_WADDR_WD-1:0] rf_waddr,
  output logic [RF_DATA_WD-1:0]  rf_wdata,
  output logic                   rf_src,
  output logic [31:0]            pend_mask,
  output logic [31:0]            stat_mu_cnt,
  output logic [31:0]            stat_force_cnt
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       head_live;
  logic [RF_WADDR_WD-1:0]     head_waddr;
  logic [RF_DATA_WD-1:0]      head_wdata;
  logic [31:0]                fifo_pend;
  logic                       push;
  logic                       mu_grant;
  logic                       kill_en;
  logic                       at_limit;
  logic [WS_TO_RF_BUS_WD-1:0] rf_bus;
  logic [SW-1:0]              starve_cnt_q, starve_cnt_d;

  // Gated by resetn so nothing is accepted or advertised during reset;
  // otherwise a function of registered occupancy only.
  assign mu_ready = resetn && !fifo_full;
  assign push     = mu_valid && mu_ready;

  rf_wport_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_bus   ({mu_waddr, mu_wdata}),
    .pop        (mu_grant),
    .kill_en    (kill_en),
    .kill_addr  (ws_waddr),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .head_live  (head_live),
    .head_waddr (head_waddr),
    .head_wdata (head_wdata),
    .pend_mask  (fifo_pend)
  );

  always_comb begin
    at_limit = (starve_cnt_q == SW'(STARVE_MAX));
    mu_grant = resetn && !fifo_empty && (!ws_we || at_limit);
    ws_stall = resetn && !fifo_empty && ws_we && at_limit;
    // Any performed WB write kills older buffered writes to the same register
    kill_en  = resetn && !mu_grant && ws_we;

    if (mu_grant) begin
      rf_bus = {head_live, head_waddr, head_wdata};
    end else begin
      rf_bus = {ws_we && (ws_waddr != '0), ws_waddr, ws_wdata};
    end
    if (!resetn) rf_bus[WS_TO_RF_BUS_WD-1] = 1'b0;

    rf_src = mu_grant ? SRC_MU : SRC_WB;
  end

  assign {rf_we, rf_waddr, rf_wdata} = rf_bus;
  assign pend_mask = resetn ? fifo_pend : '0;

  // Counts cycles a non-empty head is passed over; saturates at the limit
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || mu_grant) begin
      starve_cnt_d = '0;
    end else if (!at_limit) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) starve_cnt_q <= '0;
    else         starve_cnt_q <= starve_cnt_d;
  end

`ifdef RF_WPORT_STAT_EN
  logic [31:0] stat_mu_cnt_q, stat_mu_cnt_d;
  logic [31:0] stat_force_cnt_q, stat_force_cnt_d;

  always_comb begin
    stat_mu_cnt_d    = stat_mu_cnt_q;
    stat_force_cnt_d = stat_force_cnt_q;
    if (mu_grant) stat_mu_cnt_d    = stat_mu_cnt_q + 32'd1;
    if (ws_stall) stat_force_cnt_d = stat_force_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_mu_cnt_q    <= '0;
      stat_force_cnt_q <= '0;
    end else begin
      stat_mu_cnt_q    <= stat_mu_cnt_d;
      stat_force_cnt_q <= stat_force_cnt_d;
    end
  end

  assign stat_mu_cnt    = stat_mu_cnt_q;
  assign stat_force_cnt = stat_force_cnt_q;
`else
  assign stat_mu_cnt    = '0;
  assign stat_force_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wport_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wport_arb
//  Description : Self-checking bench for rf_wport_arb. Directed scenarios
//                followed by random traffic, all compared against a queue-based
//                reference model of the arbitration rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_wport_arb;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_we;
  logic [4:0]  ws_waddr;
  logic [31:0] ws_wdata;
  logic        ws_stall;
  logic        mu_valid;
  logic        mu_ready;
  logic [4:0]  mu_waddr;
  logic [31:0] mu_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_src;
  logic [31:0] pend_mask;
  logic [31:0] stat_mu_cnt;
  logic [31:0] stat_force_cnt;

  always #5 clk = ~clk;

  rf_wport_arb #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ws_we          (ws_we),
    .ws_waddr       (ws_waddr),
    .ws_wdata       (ws_wdata),
    .ws_stall       (ws_stall),
    .mu_valid       (mu_valid),
    .mu_ready       (mu_ready),
    .mu_waddr       (mu_waddr),
    .mu_wdata       (mu_wdata),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .rf_src         (rf_src),
    .pend_mask      (pend_mask),
    .stat_mu_cnt    (stat_mu_cnt),
    .stat_force_cnt (stat_force_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit        live;
    bit [4:0]  a;
    bit [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          m_starve    = 0;
  int          m_mu_grants = 0;
  int          m_forced    = 0;
  bit   [31:0] dut_rf[32];   // register file reconstructed from the DUT's port

  // observed values from the most recent step
  logic        o_we, o_src, o_stall, o_ready;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata, o_pend;

  task automatic step(input bit rn, input bit we, input bit [4:0] wa, input bit [31:0] wd,
                      input bit mv, input bit [4:0] ma, input bit [31:0] md);
    bit        e_ready, e_mu, e_stall, e_we, e_src, wb_write;
    bit [4:0]  e_a;
    bit [31:0] e_d, e_pend;
    int        sz;
    resetn = rn; ws_we = we; ws_waddr = wa; ws_wdata = wd;
    mu_valid = mv; mu_waddr = ma; mu_wdata = md;
    #1;
    o_we = rf_we; o_src = rf_src; o_stall = ws_stall; o_ready = mu_ready;
    o_waddr = rf_waddr; o_wdata = rf_wdata; o_pend = pend_mask;

    sz = mq.size();
    if (!rn) begin
      chk("rst_rf_we", rf_we, 0);
      chk("rst_mu_ready", mu_ready, 0);
      chk("rst_ws_stall", ws_stall, 0);
      chk("rst_rf_src", rf_src, 0);
      chk("rst_pend_mask", pend_mask, 0);
      mq.delete();
      m_starve = 0; m_mu_grants = 0; m_forced = 0;
    end else begin
      e_ready = (sz < DEPTH);
      e_mu    = (sz > 0) && (!we || m_starve == STARVE_MAX);
      e_stall = (sz > 0) && we && (m_starve == STARVE_MAX);
      if (e_mu) begin
        e_we = mq[0].live; e_a = mq[0].a; e_d = mq[0].d; e_src = 1'b1;
      end else begin
        e_we = we && (wa != 0); e_a = wa; e_d = wd; e_src = 1'b0;
      end
      e_pend = 0;
      foreach (mq[i]) if (mq[i].live && mq[i].a != 0) e_pend[mq[i].a] = 1'b1;

      chk("rf_we", rf_we, e_we);
      chk("rf_src", rf_src, e_src);
      chk("ws_stall", ws_stall, e_stall);
      chk("mu_ready", mu_ready, e_ready);
      chk("pend_mask", pend_mask, e_pend);
      chk("rf_waddr", rf_waddr, e_a);
      chk("rf_wdata", rf_wdata, e_d);

      if (rf_we) dut_rf[rf_waddr] = rf_wdata;

      // advance the model by one clock
      wb_write = !e_mu && we;
      if (e_mu) begin
        void'(mq.pop_front());
        m_mu_grants++;
        if (e_stall) m_forced++;
      end
      if (wb_write) foreach (mq[i]) if (mq[i].a == wa) mq[i].live = 1'b0;
      if (mv && e_ready) mq.push_back('{live: (ma != 0) && !(wb_write && ma == wa), a: ma, d: md});
      if (sz == 0 || e_mu) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_stats(input string tag);
`ifdef RF_WPORT_STAT_EN
    chk({tag, "_stat_mu"}, stat_mu_cnt, m_mu_grants);
    chk({tag, "_stat_force"}, stat_force_cnt, m_forced);
`else
    chk({tag, "_stat_mu_tied"}, stat_mu_cnt, 0);
    chk({tag, "_stat_force_tied"}, stat_force_cnt, 0);
`endif
  endtask

  initial begin
    resetn = 0; ws_we = 0; ws_waddr = 0; ws_wdata = 0;
    mu_valid = 0; mu_waddr = 0; mu_wdata = 0;
    @(negedge clk);

    // Reset with both requesters active
    step(0, 1, 5'd3, 32'h11, 1, 5'd7, 32'h22);
    step(0, 1, 5'd3, 32'h11, 1, 5'd7, 32'h22);
    step(1, 1, 5'd3, 32'h11, 0, 0, 0);
    chk("post_rst_we", o_we, 1);
    chk("post_rst_addr", o_waddr, 3);
    chk("post_rst_src", o_src, 0);
    chk_stats("after_reset");

    // Idle drain: single MU result goes out the next cycle
    step(1, 0, 0, 0, 1, 5'd7, 32'hAB);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("drain_src", o_src, 1);
    chk("drain_addr", o_waddr, 7);
    chk("drain_data", o_wdata, 32'hAB);
    chk("drain_pend", o_pend, 32'h80);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("drain_pend_clear", o_pend, 0);

    // Starvation: WB r9 held continuously while r4 waits
    step(1, 1, 5'd9, 32'h99, 1, 5'd4, 32'h44);
    for (int i = 0; i < STARVE_MAX; i++) begin
      step(1, 1, 5'd9, 32'h99, 0, 0, 0);
      chk("starve_wb_src", o_src, 0);
      chk("starve_wb_stall", o_stall, 0);
    end
    step(1, 1, 5'd9, 32'h99, 0, 0, 0);
    chk("forced_stall", o_stall, 1);
    chk("forced_addr", o_waddr, 4);
    chk("forced_src", o_src, 1);
    step(1, 1, 5'd9, 32'h99, 0, 0, 0);
    chk("after_force_src", o_src, 0);
    chk("after_force_addr", o_waddr, 9);
`ifdef RF_WPORT_STAT_EN
    chk("starve_force_cnt", stat_force_cnt, 1);
`endif
    chk_stats("after_starve");

    // WAW kill: buffered r5=1 is overtaken by WB r5=2
    step(1, 1, 5'd9, 32'h90, 1, 5'd5, 32'h1);
    step(1, 1, 5'd5, 32'h2, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("waw_pop_src", o_src, 1);
    chk("waw_pop_we", o_we, 0);
    chk("waw_pend5", o_pend[5], 0);
    chk("waw_r5", dut_rf[5], 32'h2);

    // Full and pointer wrap
    step(1, 1, 5'd9, 32'h91, 1, 5'd10, 32'hD0);
    step(1, 1, 5'd9, 32'h92, 1, 5'd11, 32'hD1);
    step(1, 1, 5'd9, 32'h93, 0, 0, 0);
    chk("full_ready", o_ready, 0);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 0, 1, 5'(12 + k), 32'hD2 + k);
    idle(3);

    // r0 destination is buffered dead
    step(1, 0, 0, 0, 1, 5'd0, 32'hDEAD);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("r0_src", o_src, 1);
    chk("r0_we", o_we, 0);
    chk_stats("after_r0");

    // Random traffic with a narrow address range to provoke kills
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
           $urandom, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      if (i % 50 == 49) chk_stats("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
